// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the EX stage and the RV32M multiply/divide
// sequencer. The pipeline side drives the master modport; the sequencer takes
// the slave modport.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      func3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr_in;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr_out;

    modport master (
        output start, func3, rs1_data, rs2_data, rd_addr_in, flush,
        input  busy, stall, done, result, rd_addr_out
    );

    modport slave (
        input  start, func3, rs1_data, rs2_data, rd_addr_in, flush,
        output busy, stall, done, result, rd_addr_out
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: 32-step shift-add multiplier and 32-step
// restoring divider working on operand magnitudes, with a sign fix-up on the
// last step and the RISC-V divide-by-zero / overflow cases resolved at issue.
//
// state | meaning
// IDLE  | waiting for an M instruction; stall follows start combinationally
// CALC  | one multiply or divide step per cycle, counter 0..31
// DONE  | result registered, done pulses for this single cycle
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    muldiv_sequencer_if.slave   bus_io
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REMU   = 3'b111;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        func3_q, func3_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              busy, stall, done;

    // Issue-side decode of the incoming instruction.
    logic              in_a_signed, in_b_signed;
    logic              in_a_neg, in_b_neg;
    logic [XLEN-1:0]   in_a_mag, in_b_mag;
    logic              in_div_zero, in_div_ovf;
    logic [XLEN-1:0]   special_res;

    // One iteration of each datapath, plus the signed final values.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc_step;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN:0]     div_shift, div_diff, div_rem_step;
    logic              div_ge;
    logic [XLEN-1:0]   div_quo_step;
    logic [XLEN-1:0]   quo_signed, rem_signed;
    logic [XLEN-1:0]   final_res;
    logic              neg_res;

    // Operand decode, one datapath step and final sign correction.
    always_comb begin
        in_a_signed = (bus_io.func3 != F3_MULHU) && (bus_io.func3 != F3_DIVU) &&
                      (bus_io.func3 != F3_REMU);
        in_b_signed = in_a_signed && (bus_io.func3 != F3_MULHSU);
        in_a_neg    = in_a_signed && bus_io.rs1_data[XLEN-1];
        in_b_neg    = in_b_signed && bus_io.rs2_data[XLEN-1];
        in_a_mag    = in_a_neg ? (~bus_io.rs1_data + 1'b1) : bus_io.rs1_data;
        in_b_mag    = in_b_neg ? (~bus_io.rs2_data + 1'b1) : bus_io.rs2_data;

        in_div_zero = bus_io.func3[2] && (bus_io.rs2_data == '0);
        // Only DIV/REM (func3 100/110) are signed divides.
        in_div_ovf  = bus_io.func3[2] && !bus_io.func3[0] &&
                      (bus_io.rs1_data == MIN_NEG) && (bus_io.rs2_data == ALL_ONES);
        if (in_div_zero) begin
            special_res = bus_io.func3[1] ? bus_io.rs1_data : ALL_ONES;
        end else begin
            special_res = bus_io.func3[1] ? '0 : MIN_NEG;
        end

        // Right-shifting accumulator: the multiplier sits in the low half and
        // is consumed LSB first while partial sums build up in the high half.
        mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        mul_acc_step = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring step: the dividend shifts out of quo_q MSB first while
        // quotient bits shift in at the bottom.
        div_shift    = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        div_diff     = div_shift - {1'b0, b_mag_q};
        div_ge       = !div_diff[XLEN];
        div_rem_step = div_ge ? div_diff : div_shift;
        div_quo_step = {quo_q[XLEN-2:0], div_ge};

        neg_res     = sign_a_q ^ sign_b_q;
        prod_signed = neg_res ? (~mul_acc_step + 1'b1) : mul_acc_step;
        quo_signed  = neg_res ? (~div_quo_step + 1'b1) : div_quo_step;
        rem_signed  = sign_a_q ? (~div_rem_step[XLEN-1:0] + 1'b1) : div_rem_step[XLEN-1:0];

        if (func3_q[2]) begin
            final_res = func3_q[1] ? rem_signed : quo_signed;
        end else if (func3_q == F3_MUL) begin
            final_res = prod_signed[XLEN-1:0];
        end else begin
            final_res = prod_signed[2*XLEN-1:XLEN];
        end
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        rd_d     = rd_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        busy  = (state_q == ST_CALC);
        done  = (state_q == ST_DONE) && !bus_io.flush;
        stall = rst_n_i && !bus_io.flush &&
                (((state_q == ST_IDLE) && bus_io.start) || (state_q == ST_CALC));

        if (bus_io.flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus_io.start) begin
                        func3_d  = bus_io.func3;
                        rd_d     = bus_io.rd_addr_in;
                        a_mag_d  = in_a_mag;
                        b_mag_d  = in_b_mag;
                        sign_a_d = in_a_neg;
                        sign_b_d = in_b_neg;
                        cnt_d    = '0;
                        acc_d    = {{XLEN{1'b0}}, in_b_mag};
                        rem_d    = '0;
                        quo_d    = in_a_mag;
                        if (in_div_zero || in_div_ovf) begin
                            result_d = special_res;
                            rd_out_d = bus_io.rd_addr_in;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = mul_acc_step;
                    rem_d = div_rem_step;
                    quo_d = div_quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        result_d = final_res;
                        rd_out_d = rd_q;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, latched operands and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            func3_q  <= '0;
            rd_q     <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            rd_q     <= rd_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign bus_io.busy        = busy;
    assign bus_io.stall       = stall;
    assign bus_io.done        = done;
    assign bus_io.result      = result_q;
    assign bus_io.rd_addr_out = rd_out_q;

endmodule
